// File: rtl/sdmix_dac.sv
// sdmix_dac: NCH-channel time-multiplexed stereo mixer driving two first-order sigma-delta bitstreams.
// Latency: mixed sample visible (with sample_strobe) one clock after a frame's last slot; bitstream uses it at the next sd_ce.
// Backpressure: none; free-running, each channel's inputs are sampled only in its own slot of the frame.
// Optional: define SDMIX_DITHER_EN to add 2-bit LFSR dither (x^16+x^14+x^13+x^11+1, seed 16'hACE1) to both sigma-delta sums.
module sdmix_dac #(
  parameter int NCH         = 8,
  parameter int CH_WIDTH    = 8,
  parameter int PWM_WIDTH   = 9,
  parameter int CE_DIV_LOG2 = 3
) (
  input  logic                    clk24,
  input  logic                    reset_n,
  input  logic [NCH*CH_WIDTH-1:0] ch_data,
  input  logic [NCH*2-1:0]        ch_gain,
  input  logic [NCH*2-1:0]        ch_pan,
  input  logic [NCH-1:0]          ch_mute,
  output logic                    sample_strobe,
  output logic                    o_pwm_l,
  output logic                    o_pwm_r
);

  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int SUM_W = CH_WIDTH + 3 + $clog2(NCH);
  localparam int SD_W  = PWM_WIDTH + 1;
  localparam int DIV_W = (CE_DIV_LOG2 > 0) ? CE_DIV_LOG2 : 1;

  logic [IDX_W-1:0]     ch_idx_q, ch_idx_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [SUM_W-1:0]     acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [SUM_W-1:0]     smp_l_q, smp_l_d, smp_r_q, smp_r_d;
  logic [SD_W-1:0]      sd_acc_l_q, sd_acc_l_d, sd_acc_r_q, sd_acc_r_d;
  logic                 strobe_q, strobe_d;
  logic                 pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;

  logic [CH_WIDTH-1:0]  cur_data;
  logic [1:0]           cur_gain;
  logic [1:0]           cur_pan;
  logic                 cur_mute;
  logic [SUM_W-1:0]     contrib, contrib_l, contrib_r;
  logic                 sd_ce;
  logic [PWM_WIDTH-1:0] sd_in_l, sd_in_r;
  logic [SD_W-1:0]      sd_sum_l, sd_sum_r;

  // Select the inputs of the channel visited in this slot; other channels are ignored.
  always_comb begin
    cur_data = '0;
    cur_gain = '0;
    cur_pan  = '0;
    cur_mute = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_idx_q == IDX_W'(k)) begin
        cur_data = ch_data[k*CH_WIDTH +: CH_WIDTH];
        cur_gain = ch_gain[2*k +: 2];
        cur_pan  = ch_pan[2*k +: 2];
        cur_mute = ch_mute[k];
      end
    end
  end

  assign contrib   = cur_mute ? '0 : (SUM_W'(cur_data) << cur_gain);
  assign contrib_l = cur_pan[1] ? contrib : '0;
  assign contrib_r = cur_pan[0] ? contrib : '0;

  // Mixer: accumulate one channel per clock; last slot publishes the frame sum and restarts from zero.
  always_comb begin
    ch_idx_d = (ch_idx_q == IDX_W'(NCH-1)) ? '0 : ch_idx_q + IDX_W'(1);
    acc_l_d  = acc_l_q + contrib_l;
    acc_r_d  = acc_r_q + contrib_r;
    smp_l_d  = smp_l_q;
    smp_r_d  = smp_r_q;
    strobe_d = 1'b0;
    if (ch_idx_q == IDX_W'(NCH-1)) begin
      smp_l_d  = acc_l_q + contrib_l;
      smp_r_d  = acc_r_q + contrib_r;
      acc_l_d  = '0;
      acc_r_d  = '0;
      strobe_d = 1'b1;
    end
  end

  // Sigma-delta input is the top PWM_WIDTH bits of the published sample.
  assign sd_in_l = smp_l_q[SUM_W-1 -: PWM_WIDTH];
  assign sd_in_r = smp_r_q[SUM_W-1 -: PWM_WIDTH];
  assign sd_ce   = (CE_DIV_LOG2 == 0) || (div_q == '0);

`ifdef SDMIX_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Dither source: Fibonacci LFSR stepping once per sigma-delta update.
  always_comb begin
    lfsr_d = lfsr_q;
    if (sd_ce) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  // Registered LFSR state with its own nonzero seed.
  always_ff @(posedge clk24) begin
    if (!reset_n) lfsr_q <= 16'hACE1;
    else          lfsr_q <= lfsr_d;
  end

  assign sd_sum_l = {1'b0, sd_acc_l_q[PWM_WIDTH-1:0]} + SD_W'(sd_in_l) + SD_W'(lfsr_q[1:0]);
  assign sd_sum_r = {1'b0, sd_acc_r_q[PWM_WIDTH-1:0]} + SD_W'(sd_in_r) + SD_W'(lfsr_q[1:0]);
`else
  assign sd_sum_l = {1'b0, sd_acc_l_q[PWM_WIDTH-1:0]} + SD_W'(sd_in_l);
  assign sd_sum_r = {1'b0, sd_acc_r_q[PWM_WIDTH-1:0]} + SD_W'(sd_in_r);
`endif

  // First-order modulators: carry out of the accumulator is the output bit; no reset on sample change.
  always_comb begin
    div_d      = div_q + DIV_W'(1);
    sd_acc_l_d = sd_ce ? sd_sum_l : sd_acc_l_q;
    sd_acc_r_d = sd_ce ? sd_sum_r : sd_acc_r_q;
    pwm_l_d    = sd_acc_l_q[PWM_WIDTH];
    pwm_r_d    = sd_acc_r_q[PWM_WIDTH];
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk24) begin
    if (!reset_n) begin
      ch_idx_q   <= '0;
      div_q      <= '0;
      acc_l_q    <= '0;
      acc_r_q    <= '0;
      smp_l_q    <= '0;
      smp_r_q    <= '0;
      sd_acc_l_q <= '0;
      sd_acc_r_q <= '0;
      strobe_q   <= 1'b0;
      pwm_l_q    <= 1'b0;
      pwm_r_q    <= 1'b0;
    end else begin
      ch_idx_q   <= ch_idx_d;
      div_q      <= div_d;
      acc_l_q    <= acc_l_d;
      acc_r_q    <= acc_r_d;
      smp_l_q    <= smp_l_d;
      smp_r_q    <= smp_r_d;
      sd_acc_l_q <= sd_acc_l_d;
      sd_acc_r_q <= sd_acc_r_d;
      strobe_q   <= strobe_d;
      pwm_l_q    <= pwm_l_d;
      pwm_r_q    <= pwm_r_d;
    end
  end

  assign sample_strobe = strobe_q;
  assign o_pwm_l       = pwm_l_q;
  assign o_pwm_r       = pwm_r_q;

endmodule

// File: tb/tb_sdmix_dac.sv
// tb_sdmix_dac: randomized and directed bench for sdmix_dac against an arithmetic frame/density model.
// Latency: expects each frame's sum one clock after its last slot, with sample_strobe.
// Backpressure: none; inputs driven 1 time unit after each rising edge, outputs sampled there too.
module tb_sdmix_dac;
  localparam int NCH   = 8;
  localparam int CW    = 8;
  localparam int PW    = 9;
  localparam int CED   = 3;
  localparam int SUM_W = CW + 3 + $clog2(NCH);
  localparam int SHIFT = SUM_W - PW;

  logic              clk24 = 1'b0;
  logic              reset_n;
  logic [NCH*CW-1:0] ch_data;
  logic [NCH*2-1:0]  ch_gain;
  logic [NCH*2-1:0]  ch_pan;
  logic [NCH-1:0]    ch_mute;
  logic              sample_strobe;
  logic              o_pwm_l;
  logic              o_pwm_r;

  int n_checks = 0;
  int n_fail   = 0;
  int n        = 0;   // rising edges since reset release
  int sum_l    = 0;
  int sum_r    = 0;
  int exp_l    = 0;
  int exp_r    = 0;
  int ones_l   = 0;
  int ones_r   = 0;

  always #5 clk24 = ~clk24;

  sdmix_dac #(.NCH(NCH), .CH_WIDTH(CW), .PWM_WIDTH(PW), .CE_DIV_LOG2(CED)) dut (
    .clk24        (clk24),
    .reset_n      (reset_n),
    .ch_data      (ch_data),
    .ch_gain      (ch_gain),
    .ch_pan       (ch_pan),
    .ch_mute      (ch_mute),
    .sample_strobe(sample_strobe),
    .o_pwm_l      (o_pwm_l),
    .o_pwm_r      (o_pwm_r)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Whole-frame sum of the currently held inputs, straight from the mixing rule.
  function automatic int frame_sum(input bit left);
    int s = 0;
    for (int k = 0; k < NCH; k++) begin
      if (!ch_mute[k] && ch_pan[2*k + (left ? 1 : 0)])
        s += int'(ch_data[k*CW +: CW]) * (1 << ch_gain[2*k +: 2]);
    end
    return s;
  endfunction

  // One clock: the model takes the visited channel's contribution from the inputs present at the edge.
  task automatic step();
    int ch;
    int c;
    bit frame_end;
    ch = n % NCH;
    c  = ch_mute[ch] ? 0 : int'(ch_data[ch*CW +: CW]) * (1 << ch_gain[2*ch +: 2]);
    if (ch_pan[2*ch+1]) sum_l += c;
    if (ch_pan[2*ch])   sum_r += c;
    frame_end = (ch == NCH-1);
    if (frame_end) begin
      exp_l = sum_l;
      exp_r = sum_r;
      sum_l = 0;
      sum_r = 0;
    end
    @(posedge clk24);
    #1;
    n++;
    ones_l += int'(o_pwm_l);
    ones_r += int'(o_pwm_r);
    chk("strobe", longint'(sample_strobe), longint'(frame_end));
    if (frame_end) begin
      chk("smp_l", longint'(dut.smp_l_q), exp_l);
      chk("smp_r", longint'(dut.smp_r_q), exp_r);
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    @(posedge clk24);
    #1;
    chk("rst_strobe", longint'(sample_strobe), 0);
    chk("rst_pwm_l", longint'(o_pwm_l), 0);
    chk("rst_pwm_r", longint'(o_pwm_r), 0);
    chk("rst_smp_l", longint'(dut.smp_l_q), 0);
    chk("rst_smp_r", longint'(dut.smp_r_q), 0);
    reset_n = 1'b1;
    n = 0;
    sum_l = 0;
    sum_r = 0;
  endtask

  // Over any 512 consecutive sd_ce periods with a constant input, the ones count is exactly the input;
  // each output bit is held for 2^CED clocks, so 512*2^CED clocks hold input*2^CED ones.
  task automatic density(input string tag, input int in_l, input int in_r);
    repeat (64) step();
    ones_l = 0;
    ones_r = 0;
    repeat (512 * (1 << CED)) step();
    chk({tag, "_dens_l"}, ones_l, in_l * (1 << CED));
    chk({tag, "_dens_r"}, ones_r, in_r * (1 << CED));
  endtask

  task automatic set_ch0_only(input logic [1:0] pan);
    ch_data = '0;
    ch_gain = '0;
    ch_pan  = '0;
    ch_mute = '0;
    ch_data[CW-1:0] = 8'hFF;
    ch_gain[1:0]    = 2'd3;
    ch_pan[1:0]     = pan;
  endtask

  initial begin
    int first;
    reset_n = 1'b0;
    ch_data = '0;
    ch_gain = '0;
    ch_pan  = '0;
    ch_mute = '0;
    apply_reset();

    // Silence: no ones, strobe every NCH clocks.
    ch_pan = '1;
    density("zero", 0, 0);

    // Single full-scale channel: 2040 -> sigma-delta input 63.
    set_ch0_only(2'b11);
    chk("ch0_model", frame_sum(1'b1), 2040);
    density("ch0", 2040 >> SHIFT, 2040 >> SHIFT);

    // All channels full scale: 16320 -> 510, no wrap.
    ch_data = '1;
    ch_gain = '1;
    ch_pan  = '1;
    density("all", 16320 >> SHIFT, 16320 >> SHIFT);

    // Left-only pan, then mute.
    set_ch0_only(2'b10);
    density("panl", 63, 0);
    ch_mute[0] = 1'b1;
    density("mute", 0, 0);

    // One-clock glitch on channel 3 outside its slot must not reach the frame sum.
    set_ch0_only(2'b11);
    ch_pan[7:6] = 2'b11;
    repeat (2 * NCH) step();
    while (n % NCH != 5) step();
    ch_data[3*CW +: CW] = 8'hFF;
    step();
    ch_data[3*CW +: CW] = 8'h00;
    while (n % NCH != 0) step();
    chk("glitch_smp_l", longint'(dut.smp_l_q), 2040);
    chk("glitch_smp_r", longint'(dut.smp_r_q), 2040);

    // Reset in the slot of channel 4: partial sums dropped, first strobe in cycle NCH+1
    // counting the first clock period with reset released as cycle 1.
    ch_data = '1;
    ch_gain = '1;
    ch_pan  = '1;
    while (n % NCH != 4) step();
    apply_reset();
    set_ch0_only(2'b11);
    first = -1;
    for (int i = 1; i <= NCH + 2; i++) begin
      step();
      if (sample_strobe && first < 0) first = i + 1;
    end
    chk("first_strobe_cycle", first, NCH + 1);

    // Fully random inputs changing every clock, checked frame by frame.
    repeat (24 * NCH) begin
      ch_data = {$urandom, $urandom};
      ch_gain = NCH*2'($urandom);
      ch_pan  = NCH*2'($urandom);
      ch_mute = NCH'($urandom & $urandom);
      step();
    end

    // Random held configurations checked through bitstream density.
    for (int r = 0; r < 3; r++) begin
      ch_data = {$urandom, $urandom};
      ch_gain = NCH*2'($urandom);
      ch_pan  = NCH*2'($urandom);
      ch_mute = NCH'($urandom & $urandom);
      density("rand", frame_sum(1'b1) >> SHIFT, frame_sum(1'b0) >> SHIFT);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
